// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_if
//  Description : Raster timing bundle between vga_timing_gen and the shader
//                stage / sync pins.
//                master : driven by the timing generator
//                slave  : consumed by the shader stage and pin logic
//  Signals     : pix_en      - one system-clock pulse per pixel
//                hcount      - pixel column (12 bits)
//                vcount      - line number (12 bits)
//                active      - visible-area flag
//                hsync/vsync - sync levels (polarity set by the generator)
//                line_start  - pulse when hcount becomes 0
//                frame_start - pulse when (hcount,vcount) becomes (0,0)
//                frame_count - 8-bit frame counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_if;
  logic        pix_en;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        active;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output pix_en, hcount, vcount, active, hsync, vsync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_en, hcount, vcount, active, hsync, vsync,
           line_start, frame_start, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Divides the system clock into a one-cycle pixel enable and
//                runs the raster counters (800x600 by default), producing
//                hsync, vsync, active, line/frame strobes and a frame counter.
//                Every output is registered from the next-state counts, so
//                active/hsync/vsync always describe the (hcount,vcount)
//                currently on the outputs.
//  Ports       : clock - system clock
//                reset - asynchronous assert, synchronous release, active-high
//                vga   - vga_timing_if.master (see interface for the fields)
//  Config      : SYNC_DELAY_EN - when defined, hsync/vsync/active pass through
//                a PIPE_DELAY-stage shift register advanced on pix_en so the
//                pin syncs line up with a shader of PIPE_DELAY pixels latency.
//                Counts, strobes and frame_count are never delayed.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV    = 3,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  wire logic     clock,
  input  wire logic     reset,
  vga_timing_if.master  vga
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0]      c_H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0]      c_V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0]      c_H_ACTIVE  = 12'(H_ACTIVE);
  localparam logic [11:0]      c_V_ACTIVE  = 12'(V_ACTIVE);
  localparam logic [11:0]      c_HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]      c_HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0]      c_VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0]      c_VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [11:0]      hcount_q, hcount_d;
  logic [11:0]      vcount_q, vcount_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_count_q, frame_count_d;

  logic [11:0]      h_next;
  logic [11:0]      v_next;

  // Position the raster moves to on the next pixel enable.
  always_comb begin
    h_next = (hcount_q == c_H_LAST) ? 12'd0 : hcount_q + 12'd1;
    v_next = vcount_q;
    if (hcount_q == c_H_LAST) begin
      v_next = (vcount_q == c_V_LAST) ? 12'd0 : vcount_q + 12'd1;
    end
  end

  always_comb begin
    div_d         = div_q + DIV_W'(1);
    pix_en_d      = 1'b0;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;

    if (div_q == c_DIV_LAST) begin
      div_d         = '0;
      pix_en_d      = 1'b1;
      hcount_d      = h_next;
      vcount_d      = v_next;
      // Decoded from the next-state counts so the flags land together
      // with the counts they describe.
      active_d      = (h_next < c_H_ACTIVE) && (v_next < c_V_ACTIVE);
      hsync_d       = ((h_next >= c_HS_START) && (h_next < c_HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_next >= c_VS_START) && (v_next < c_VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_next == 12'd0);
      frame_start_d = (h_next == 12'd0) && (v_next == 12'd0);
      if ((h_next == 12'd0) && (v_next == 12'd0)) begin
        frame_count_d = frame_count_q + 8'd1;
      end
    end
  end

  // Counters sit at the last position during reset so the first pixel
  // enable wraps to (0,0) and raises frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      hcount_q      <= c_H_LAST;
      vcount_q      <= c_V_LAST;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

`ifdef SYNC_DELAY_EN
  logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q,  hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q,  vs_pipe_d;

  // Stage 0 captures the value being replaced on this pixel enable, so
  // stage PIPE_DELAY-1 carries the flags of PIPE_DELAY pixels ago.
  always_comb begin
    act_pipe_d = act_pipe_q;
    hs_pipe_d  = hs_pipe_q;
    vs_pipe_d  = vs_pipe_q;
    if (pix_en_d) begin
      act_pipe_d[0] = active_q;
      hs_pipe_d[0]  = hsync_q;
      vs_pipe_d[0]  = vsync_q;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        act_pipe_d[i] = act_pipe_q[i-1];
        hs_pipe_d[i]  = hs_pipe_q[i-1];
        vs_pipe_d[i]  = vs_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_pipe_q <= '0;
      hs_pipe_q  <= {PIPE_DELAY{~HS_POL}};
      vs_pipe_q  <= {PIPE_DELAY{~VS_POL}};
    end else begin
      act_pipe_q <= act_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
    end
  end

  assign vga.active = act_pipe_q[PIPE_DELAY-1];
  assign vga.hsync  = hs_pipe_q[PIPE_DELAY-1];
  assign vga.vsync  = vs_pipe_q[PIPE_DELAY-1];
`else
  // PIPE_DELAY has no effect without the alignment delay; this empty block
  // only keeps the parameter referenced in this build.
  if (PIPE_DELAY < 0) begin : g_pipe_delay_unused
  end

  assign vga.active = active_q;
  assign vga.hsync  = hsync_q;
  assign vga.vsync  = vsync_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. DUT A uses the
//                default 800x600 timing; DUT B uses a tiny raster (10x6,
//                CLK_DIV=2, active-high hsync) so whole frames and the
//                frame_count wrap fit in a short run. Both are compared every
//                cycle against a position-arithmetic reference model, plus a
//                vector table and hand sequences for line timing, counter
//                wrap and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef SYNC_DELAY_EN
  localparam int TB_DLY = 2;
`else
  localparam int TB_DLY = 0;
`endif

  typedef struct {
    bit pix_en;
    int h;
    int v;
    bit active;
    bit hsync;
    bit vsync;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  typedef struct {
    int cyc;
    bit pix_en;
    int h;
    int v;
    bit active;
    bit hsync;
    bit ls;
    bit fs;
    int fc;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   mc    = 0;     // clock edges since reset release
  int   checks = 0;
  int   errors = 0;

  vga_timing_if ifa ();
  vga_timing_if ifb ();

  vga_timing_gen #(.PIPE_DELAY(2)) dut_a (
    .clock (clk),
    .reset (reset),
    .vga   (ifa.master)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DELAY(2)
  ) dut_b (
    .clock (clk),
    .reset (reset),
    .vga   (ifb.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) mc <= 0;
    else       mc <= mc + 1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, cycle %0d)", name, act, exp, $time, mc);
    end
  endtask

  // Reference: after c clocks there have been k = c/div pixel enables;
  // pixel k (k>=1) sits at raster position (k-1) mod frame_size.
  function automatic exp_t model(input int c, input int div,
                                 input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp,
                                 input bit hpol, input bit vpol, input int dly);
    exp_t e;
    int ht, vt, k, p, j, pj, hj, vj;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    k  = c / div;
    e.pix_en = (c > 0) && (c % div == 0);
    if (k == 0) begin
      e.h = ht - 1; e.v = vt - 1; e.ls = 0; e.fs = 0; e.fc = 0;
    end else begin
      p    = (k - 1) % (ht * vt);
      e.h  = p % ht;
      e.v  = p / ht;
      e.ls = e.pix_en && (e.h == 0);
      e.fs = e.pix_en && (p == 0);
      e.fc = ((k - 1) / (ht * vt) + 1) % 256;
    end
    j = k - dly;
    if (j <= 0) begin
      e.active = 0; e.hsync = ~hpol; e.vsync = ~vpol;
    end else begin
      pj = (j - 1) % (ht * vt);
      hj = pj % ht;
      vj = pj / ht;
      e.active = (hj < ha) && (vj < va);
      e.hsync  = ((hj >= ha + hfp) && (hj < ha + hfp + hs)) ? hpol : ~hpol;
      e.vsync  = ((vj >= va + vfp) && (vj < va + vfp + vs)) ? vpol : ~vpol;
    end
    return e;
  endfunction

  // Continuous comparison of both DUTs against the model.
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(mc, 3, 800, 40, 128, 88, 600, 1, 4, 23, 1'b0, 1'b0, TB_DLY);
    eb = model(mc, 2, 6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0, TB_DLY);
    cmp("A.pix_en", ifa.pix_en, ea.pix_en);
    cmp("A.hcount", ifa.hcount, ea.h);
    cmp("A.vcount", ifa.vcount, ea.v);
    cmp("A.active", ifa.active, ea.active);
    cmp("A.hsync", ifa.hsync, ea.hsync);
    cmp("A.vsync", ifa.vsync, ea.vsync);
    cmp("A.line_start", ifa.line_start, ea.ls);
    cmp("A.frame_start", ifa.frame_start, ea.fs);
    cmp("A.frame_count", ifa.frame_count, ea.fc);
    cmp("B.pix_en", ifb.pix_en, eb.pix_en);
    cmp("B.hcount", ifb.hcount, eb.h);
    cmp("B.vcount", ifb.vcount, eb.v);
    cmp("B.active", ifb.active, eb.active);
    cmp("B.hsync", ifb.hsync, eb.hsync);
    cmp("B.vsync", ifb.vsync, eb.vsync);
    cmp("B.line_start", ifb.line_start, eb.ls);
    cmp("B.frame_start", ifb.frame_start, eb.fs);
    cmp("B.frame_count", ifb.frame_count, eb.fc);
  end

  task automatic release_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, ".rst_pix_en"}, ifa.pix_en, 0);
    cmp({tag, ".rst_hcount"}, ifa.hcount, 1055);
    cmp({tag, ".rst_vcount"}, ifa.vcount, 627);
    cmp({tag, ".rst_active"}, ifa.active, 0);
    cmp({tag, ".rst_hsync"}, ifa.hsync, 1);
    cmp({tag, ".rst_vsync"}, ifa.vsync, 1);
    cmp({tag, ".rst_strobes"}, {ifa.line_start, ifa.frame_start}, 0);
    cmp({tag, ".rst_frame_count"}, ifa.frame_count, 0);
    cmp({tag, ".rst_B_hcount"}, ifb.hcount, 9);
    cmp({tag, ".rst_B_vcount"}, ifb.vcount, 5);
    cmp({tag, ".rst_B_hsync"}, ifb.hsync, 0);
  endtask

  vec_t vecs[$];
  int   hs_cnt, act_cnt, ls_cnt, vi;

  initial begin
    // Expected DUT A behaviour with zero sync delay; pixel k appears on
    // clock 3k at column k-1.
    vecs.push_back('{1,    0, 1055, 627, 0, 1, 0, 0, 0});
    vecs.push_back('{2,    0, 1055, 627, 0, 1, 0, 0, 0});
    vecs.push_back('{3,    1, 0,    0,   1, 1, 1, 1, 1});
    vecs.push_back('{4,    0, 0,    0,   1, 1, 0, 0, 1});
    vecs.push_back('{6,    1, 1,    0,   1, 1, 0, 0, 1});
    vecs.push_back('{2400, 1, 799,  0,   1, 1, 0, 0, 1});
    vecs.push_back('{2403, 1, 800,  0,   0, 1, 0, 0, 1});
    vecs.push_back('{2520, 1, 839,  0,   0, 1, 0, 0, 1});
    vecs.push_back('{2523, 1, 840,  0,   0, 0, 0, 0, 1});
    vecs.push_back('{2904, 1, 967,  0,   0, 0, 0, 0, 1});
    vecs.push_back('{2907, 1, 968,  0,   0, 1, 0, 0, 1});
    vecs.push_back('{3168, 1, 1055, 0,   0, 1, 0, 0, 1});
    vecs.push_back('{3171, 1, 0,    1,   1, 1, 1, 0, 1});
    vecs.push_back('{3172, 0, 0,    1,   1, 1, 0, 0, 1});

    repeat (3) @(posedge clk);
    #1 check_reset_values("init");
    release_reset();

    // Walk one full line of DUT A, checking the table entries on the way and
    // tallying pixel-enable cycles with hsync asserted / active high.
    hs_cnt = 0; act_cnt = 0; ls_cnt = 0; vi = 0;
    while (mc < 3172) begin
      @(negedge clk);
      if (ifa.pix_en && mc <= 3168) begin
        if (ifa.hsync == 1'b0) hs_cnt++;
        if (ifa.active) act_cnt++;
      end
      if (ifa.line_start) ls_cnt++;
      if (vi < vecs.size() && vecs[vi].cyc == mc) begin
        cmp("tbl.pix_en", ifa.pix_en, vecs[vi].pix_en);
        cmp("tbl.hcount", ifa.hcount, vecs[vi].h);
        cmp("tbl.vcount", ifa.vcount, vecs[vi].v);
`ifndef SYNC_DELAY_EN
        cmp("tbl.active", ifa.active, vecs[vi].active);
        cmp("tbl.hsync", ifa.hsync, vecs[vi].hsync);
`endif
        cmp("tbl.line_start", ifa.line_start, vecs[vi].ls);
        cmp("tbl.frame_start", ifa.frame_start, vecs[vi].fs);
        cmp("tbl.frame_count", ifa.frame_count, vecs[vi].fc);
        vi++;
      end
    end
    cmp("line.vectors_applied", vi, 14);
    cmp("line.hsync_pixels", hs_cnt, 128);
    cmp("line.active_pixels", act_cnt, 800);
    cmp("line.line_starts", ls_cnt, 2);

    // DUT B: 60 pixels per frame at 2 clocks/pixel; the 256th frame_start
    // lands on clock 2*(255*60+1) = 30602 and wraps frame_count to 0.
    while (mc < 30600) @(negedge clk);
    cmp("wrap.fc_before", ifb.frame_count, 255);
    @(negedge clk);
    @(negedge clk);
    cmp("wrap.cycle", mc, 30602);
    cmp("wrap.frame_start", ifb.frame_start, 1);
    cmp("wrap.fc_after", ifb.frame_count, 0);

    // Asynchronous reset mid-frame: outputs must be at reset values
    // before the next clock edge.
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("restart.pix_en", ifa.pix_en, 1);
    cmp("restart.frame_start", ifa.frame_start, 1);
    cmp("restart.hcount", ifa.hcount, 0);
    cmp("restart.frame_count", ifa.frame_count, 1);

    // Random reset pulses of random length and phase; the continuous
    // checker covers every cycle in between.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 4)) reset = 1'b1;
      #1 cmp("rand.async_hcount", ifa.hcount, 1055);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      release_reset();
    end
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
